tsc_seq_power: RTL and testbench
================================

# tsc_seq_power

Parametrised trigger/payload block for the DES/AES hardware-Trojan benchmark family, used for HT-detection research. It watches the cipher state bus for an ordered sequence of SEQ_LEN plaintext patterns and then arms. While armed, it rotates NUM_CH independent LOAD_W-bit load registers at a programmable rate to raise dynamic power. It sits beside the cipher core on the same clock, taps the state bus read-only, and never alters cipher datapath behaviour.

## Interface
Parameters:
- STATE_W, 64, width of monitored state bus
- SEQ_LEN, 2, number of patterns in trigger sequence, legal range 1..8
- SEQ_PAT, {64'h8899aabbccddeeff, 64'h0011223344556677}, packed SEQ_LEN*STATE_W; element 0 is in the LSBs and is matched first
- DEACT_PAT, 64'hffeeddccbbaa9988, deactivation pattern; used only with TSC_DEACT_EN
- LOAD_W, 128, width of each load register
- NUM_CH, 2, number of load registers, legal range 1..8
- LOAD_INIT, 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa, reset value of every load register
- ROT_DIV_LOG2, 0, rotation period is 2^ROT_DIV_LOG2 armed cycles, legal range 0..8

Ports:
- clk, in, 1, rising-edge clock
- rst, in, 1, reset; synchronous, active-high
- state_vld, in, 1, state is sampled only when high
- state, in, STATE_W, cipher state bus
- trig, out, 1, registered armed flag
- seq_idx, out, 3, number of sequence patterns matched so far
- load_tap, out, NUM_CH, bit 0 of each load register
- act_cnt, out, 16, count of rotation events; saturates at 16'hffff

## Operation
- Fully synchronous. No latches and no combinational sensitivity to state.
- FSM states: IDLE, MATCH, ARMED. seq_idx is 0 in IDLE, 1..SEQ_LEN-1 in MATCH, and frozen at its last value in ARMED.
- IDLE/MATCH, on a cycle with state_vld=1:
  - If state==SEQ_PAT[seq_idx]: seq_idx increments. When the increment would reach SEQ_LEN, go to ARMED.
  - Else if state==SEQ_PAT[0]: seq_idx=1 (restart). With SEQ_LEN=1 this arms instead.
  - Else: seq_idx=0, go to IDLE.
- On cycles with state_vld=0, FSM and seq_idx hold. Gaps do not break a sequence.
- ARMED: trig=1 and sequence matching is ignored.
- Prescaler:
  - Counter is ROT_DIV_LOG2 bits wide and increments each armed cycle, wrapping.
  - A rotation event fires when the counter is all-ones. With ROT_DIV_LOG2=0, an event fires every armed cycle.
- On a rotation event:
  - Even-index channels rotate right by 1: {r[0], r[LOAD_W-1:1]}.
  - Odd-index channels rotate left by 1: {r[LOAD_W-2:0], r[LOAD_W-1]}.
  - act_cnt increments, saturating.
- Outside ARMED, load registers, prescaler and act_cnt hold.
- Reset values: FSM=IDLE, seq_idx=0, trig=0, all load registers=LOAD_INIT, prescaler=0, act_cnt=0, load_tap = bit 0 of LOAD_INIT for each channel (0 for default).
- rst dominates every other event, including when it is asserted mid-sequence or while ARMED.

## Timing
- The edge that samples the final pattern moves the FSM to ARMED. trig is high from that edge onward, giving 1 cycle of latency from the final pattern.
- The first rotation occurs on the edge 2^ROT_DIV_LOG2 cycles after the arming edge. With ROT_DIV_LOG2=0, that is the next edge.
- load_tap and act_cnt are registered and reflect a rotation at the same edge it occurs.
- A pattern and its restart-match are resolved in the same cycle. No pattern is consumed twice.

## Configuration
- TSC_DEACT_EN defined:
  - In ARMED, a cycle with state_vld=1 and state==DEACT_PAT returns the FSM to IDLE at that edge.
  - trig drops, seq_idx=0 and the prescaler clears.
  - Load registers and act_cnt hold their values and are not reloaded. Re-arming resumes rotation from the held values.
  - A rotation event coincident with deactivation is suppressed.
- TSC_DEACT_EN undefined: ARMED is left only by rst, and DEACT_PAT is unused.

## Test plan
Defaults unless noted.
- Reset check: rst high for 2 cycles -> trig=0, seq_idx=0, act_cnt=0, load_tap=2'b00, all load registers=LOAD_INIT.
- Arm and rotate: vld 0011223344556677, then vld 8899aabbccddeeff -> seq_idx goes 1 then ARMED, trig=1 at the second edge. Next edge: ch0=5555…, ch1=5555…, load_tap=2'b11, act_cnt=1. After 4 events, act_cnt=4 and load_tap=2'b00.
- Gap and restart: vld P0, three cycles with vld=0, vld P0, vld P1 -> arms on P1. vld P0 followed by vld 0 -> seq_idx=0 and trig stays 0.
- Prescaler: ROT_DIV_LOG2=2, arm, then run 12 armed cycles -> exactly 3 rotation events, at armed cycles 4, 8 and 12, with act_cnt=3.
- Deactivate (TSC_DEACT_EN): arm, wait 3 events, vld DEACT_PAT -> trig=0 the next cycle, act_cnt stays 3 and registers hold. Re-arm -> act_cnt continues to 4. Without the macro, DEACT_PAT leaves trig=1.
- Reset mid-operation: rst while ARMED with act_cnt=5 -> all outputs return to reset values at that edge.

Source files
------------

// File: rtl/tsc_seq_power.sv
// Sequence-armed power-load block: watches the cipher state bus for an ordered
// pattern sequence, then rotates load registers. Optional TSC_DEACT_EN adds a deactivation pattern.
module tsc_seq_power #(
  parameter int                         STATE_W      = 64,
  parameter int                         SEQ_LEN      = 2,
  parameter logic [SEQ_LEN*STATE_W-1:0] SEQ_PAT      = {64'h8899aabbccddeeff, 64'h0011223344556677},
  parameter logic [STATE_W-1:0]         DEACT_PAT    = 64'hffeeddccbbaa9988,
  parameter int                         LOAD_W       = 128,
  parameter int                         NUM_CH       = 2,
  parameter logic [LOAD_W-1:0]          LOAD_INIT    = {4{32'haaaaaaaa}},
  parameter int                         ROT_DIV_LOG2 = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               state_vld,
  input  logic [STATE_W-1:0] state,
  output logic               trig,
  output logic [2:0]         seq_idx,
  output logic [NUM_CH-1:0]  load_tap,
  output logic [15:0]        act_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MATCH = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;

  localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);

  logic [1:0]         fsm_q;
  logic [1:0]         fsm_d;
  logic [2:0]         seq_d;
  logic               armed;
  logic               hit_cur;
  logic               hit_first;
  logic               deact;
  logic               pre_full;
  logic               rot_evt;
  logic [STATE_W-1:0] pat [8];
  logic [LOAD_W-1:0]  load_q  [NUM_CH];
  logic [LOAD_W-1:0]  rot_val [NUM_CH];

  // Eight slots so a 3-bit seq_idx always indexes in range; unused slots mirror pattern 0.
  for (genvar i = 0; i < 8; i++) begin : g_pat
    if (i < SEQ_LEN) begin : g_used
      assign pat[i] = SEQ_PAT[i*STATE_W +: STATE_W];
    end else begin : g_pad
      assign pat[i] = SEQ_PAT[STATE_W-1:0];
    end
  end

  assign armed     = (fsm_q == ARMED);
  assign hit_cur   = (state == pat[seq_idx]);
  assign hit_first = (state == pat[0]);
  assign trig      = armed;

`ifdef TSC_DEACT_EN
  assign deact = armed && state_vld && (state == DEACT_PAT);
`else
  logic unused_deact_pat;
  assign unused_deact_pat = ^DEACT_PAT;
  assign deact            = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d = fsm_q;
    seq_d = seq_idx;
    if (armed) begin
      if (deact) begin
        fsm_d = IDLE;
        seq_d = '0;
      end
    end else if (state_vld) begin
      if (hit_cur) begin
        // Arming keeps seq_idx at its last matched index rather than overflowing.
        if (seq_idx == LAST_IDX) begin
          fsm_d = ARMED;
        end else begin
          fsm_d = MATCH;
          seq_d = seq_idx + 3'd1;
        end
      end else if (hit_first) begin
        if (SEQ_LEN == 1) begin
          fsm_d = ARMED;
        end else begin
          fsm_d = MATCH;
          seq_d = 3'd1;
        end
      end else begin
        fsm_d = IDLE;
        seq_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      seq_idx <= '0;
    end else begin
      fsm_q   <= fsm_d;
      seq_idx <= seq_d;
    end
  end

  if (ROT_DIV_LOG2 == 0) begin : g_nodiv
    assign pre_full = 1'b1;
  end else begin : g_div
    logic [ROT_DIV_LOG2-1:0] pre_q;

    always_ff @(posedge clk) begin
      if (rst || deact) begin
        pre_q <= '0;
      end else if (armed) begin
        pre_q <= pre_q + ROT_DIV_LOG2'(1);
      end
    end

    assign pre_full = &pre_q;
  end

  // A rotation coincident with deactivation is dropped.
  assign rot_evt = armed && !deact && pre_full;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (c % 2 == 1) begin : g_left
      assign rot_val[c] = {load_q[c][LOAD_W-2:0], load_q[c][LOAD_W-1]};
    end else begin : g_right
      assign rot_val[c] = {load_q[c][0], load_q[c][LOAD_W-1:1]};
    end
    assign load_tap[c] = load_q[c][0];
  end

  // NOTE: the load array is real architectural state with a defined start value, so it is reset like any flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) load_q[c] <= LOAD_INIT;
    end else if (rot_evt) begin
      for (int c = 0; c < NUM_CH; c++) load_q[c] <= rot_val[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt <= '0;
    end else if (rot_evt && (act_cnt != 16'hffff)) begin
      act_cnt <= act_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tsc_seq_power.sv
// Directed bench for tsc_seq_power: a default instance and a ROT_DIV_LOG2=2 instance
// share the same stimulus; expectations are hand-computed.
module tb_tsc_seq_power;

  localparam logic [63:0]  P0   = 64'h0011223344556677;
  localparam logic [63:0]  P1   = 64'h8899aabbccddeeff;
  localparam logic [63:0]  PD   = 64'hffeeddccbbaa9988;
  localparam logic [127:0] INIT = {4{32'haaaaaaaa}};
  localparam logic [127:0] ALT  = {4{32'h55555555}};

  logic        clk = 1'b0;
  logic        rst;
  logic        state_vld;
  logic [63:0] state;

  logic        trig, trig_p;
  logic [2:0]  seq_idx, seq_idx_p;
  logic [1:0]  load_tap, load_tap_p;
  logic [15:0] act_cnt, act_cnt_p;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tsc_seq_power dut (
    .clk      (clk),
    .rst      (rst),
    .state_vld(state_vld),
    .state    (state),
    .trig     (trig),
    .seq_idx  (seq_idx),
    .load_tap (load_tap),
    .act_cnt  (act_cnt)
  );

  tsc_seq_power #(.ROT_DIV_LOG2(2)) dut_p (
    .clk      (clk),
    .rst      (rst),
    .state_vld(state_vld),
    .state    (state),
    .trig     (trig_p),
    .seq_idx  (seq_idx_p),
    .load_tap (load_tap_p),
    .act_cnt  (act_cnt_p)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic v, input logic [63:0] s);
    @(negedge clk);
    rst       = r;
    state_vld = v;
    state     = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    state_vld = 1'b0;
    state     = '0;

    // Reset state
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("rst_trig",     trig,            1'b0);
    check("rst_seq",      seq_idx,         3'd0);
    check("rst_act",      act_cnt,         16'd0);
    check("rst_tap",      load_tap,        2'b00);
    check("rst_ld0",      dut.load_q[0],   INIT);
    check("rst_ld1",      dut.load_q[1],   INIT);
    check("rst_p_trig",   trig_p,          1'b0);

    // P1 first from IDLE is not the start of the sequence
    step(1'b0, 1'b1, P1);
    check("idle_p1_seq",  seq_idx,         3'd0);

    // Arm
    step(1'b0, 1'b1, P0);
    check("m1_seq",       seq_idx,         3'd1);
    check("m1_trig",      trig,            1'b0);
    step(1'b0, 1'b1, P1);
    check("arm_trig",     trig,            1'b1);
    check("arm_seq",      seq_idx,         3'd1);
    check("arm_act",      act_cnt,         16'd0);
    check("arm_p_trig",   trig_p,          1'b1);

    // First rotation on the next edge
    step(1'b0, 1'b0, '0);
    check("r1_ld0",       dut.load_q[0],   ALT);
    check("r1_ld1",       dut.load_q[1],   ALT);
    check("r1_tap",       load_tap,        2'b11);
    check("r1_act",       act_cnt,         16'd1);
    check("r1_p_act",     act_cnt_p,       16'd0);

    // Armed cycles 2..12: default rotates every cycle, divided one every 4th
    for (int k = 2; k <= 12; k++) begin
      step(1'b0, 1'b0, '0);
      check($sformatf("run%0d_act", k),   act_cnt,    16'(k));
      check($sformatf("run%0d_tap", k),   load_tap,   (k % 2 == 1) ? 2'b11 : 2'b00);
      check($sformatf("run%0d_p_act", k), act_cnt_p,  16'(k / 4));
      check($sformatf("run%0d_p_tap", k), load_tap_p, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
    end
    check("run_ld0_back", dut.load_q[0],   INIT);

`ifdef TSC_DEACT_EN
    step(1'b0, 1'b1, PD);
    check("deact_trig",   trig,            1'b0);
    check("deact_seq",    seq_idx,         3'd0);
    check("deact_act",    act_cnt,         16'd12);
    check("deact_ld0",    dut.load_q[0],   INIT);
    check("deact_p_act",  act_cnt_p,       16'd3);
    step(1'b0, 1'b0, '0);
    check("deact_hold",   act_cnt,         16'd12);
    step(1'b0, 1'b1, P0);
    step(1'b0, 1'b1, P1);
    check("rearm_trig",   trig,            1'b1);
    step(1'b0, 1'b0, '0);
    check("rearm_act",    act_cnt,         16'd13);
    check("rearm_ld0",    dut.load_q[0],   ALT);
    check("rearm_p_act",  act_cnt_p,       16'd3);
`else
    step(1'b0, 1'b1, PD);
    check("nodeact_trig", trig,            1'b1);
    check("nodeact_act",  act_cnt,         16'd13);
    check("nodeact_p",    act_cnt_p,       16'd3);
    // Matching is ignored while armed
    step(1'b0, 1'b1, P0);
    check("armed_p0_seq", seq_idx,         3'd1);
    check("armed_p0_act", act_cnt,         16'd14);
`endif

    // Reset while armed
    step(1'b1, 1'b1, P0);
    check("mrst_trig",    trig,            1'b0);
    check("mrst_seq",     seq_idx,         3'd0);
    check("mrst_act",     act_cnt,         16'd0);
    check("mrst_tap",     load_tap,        2'b00);
    check("mrst_ld1",     dut.load_q[1],   INIT);
    check("mrst_p_act",   act_cnt_p,       16'd0);
    check("mrst_p_trig",  trig_p,          1'b0);

    // Gaps hold the sequence; a repeated P0 restarts at index 1
    step(1'b0, 1'b1, P0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, P1);
      check($sformatf("gap%0d_seq", g), seq_idx, 3'd1);
    end
    check("gap_trig",     trig,            1'b0);
    step(1'b0, 1'b1, P0);
    check("restart_seq",  seq_idx,         3'd1);
    check("restart_trig", trig,            1'b0);
    step(1'b0, 1'b1, P1);
    check("gap_arm",      trig,            1'b1);
    check("gap_act0",     act_cnt,         16'd0);

    // Mismatch in MATCH returns to IDLE
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, P0);
    step(1'b0, 1'b1, 64'd0);
    check("miss_seq",     seq_idx,         3'd0);
    check("miss_trig",    trig,            1'b0);
    step(1'b0, 1'b1, P1);
    check("miss_p1_trig", trig,            1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
